// File: rtl/ex_md_unit.sv
// ============================================================================
// ex_md_unit
// ----------------------------------------------------------------------------
// Iterative multiply/divide unit for the milano EX stage.  One RV32M-style
// operation is in flight at a time.  Multiplies run through a short counted
// pipeline.  Divides and remainders use a restoring divider that produces one
// quotient bit per cycle and then applies a sign-fix cycle.  Division by zero
// and signed overflow can finish early.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_valid_i         operation request
//   req_ready_o         unit is idle and not being flushed
//   op_i                0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   operand_a_i/_b_i    rs1 / rs2 values
//   rd_addr_i, rd_we_i  destination register and write enable
//   kill_i              pipeline flush, aborts any operation in flight
//   resp_valid_o        one-cycle result strobe
//   resp_rd_we_o        write enable for the result (0 when no strobe or rd=0)
//   resp_rd_waddr_o     destination register of the result
//   resp_wdata_o        result data
//   busy_o              an operation is in flight
//   stallreq_o          stall request towards ctrl
// ============================================================================
module ex_md_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int EARLY_OUT  = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_we_i,
    input  logic            kill_i,
    output logic            resp_valid_o,
    output logic            resp_rd_we_o,
    output logic [4:0]      resp_rd_waddr_o,
    output logic [XLEN-1:0] resp_wdata_o,
    output logic            busy_o,
    output logic            stallreq_o
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_e;

    state_e          state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]      op_q;
    // a_q: multiplicand, or dividend shifting out while quotient shifts in.
    // b_q: multiplier, or divisor magnitude.
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] spec_res_q;
    logic [XLEN-1:0] last_wdata_q;
    logic [4:0]      rd_q;
    logic [4:0]      last_waddr_q;
    logic            we_q;
    logic            special_q;
    logic            neg_quo_q;
    logic            neg_rem_q;

    // ------------------------------------------------------------------
    // Request-side decode, evaluated on the accept edge only
    // ------------------------------------------------------------------
    logic            is_div_d;
    logic            div_signed_d;
    logic            div_zero_d;
    logic            ovf_d;
    logic [XLEN-1:0] abs_a_d;
    logic [XLEN-1:0] abs_b_d;
    logic [XLEN-1:0] spec_res_d;

    assign is_div_d     = op_i[2];
    assign div_signed_d = is_div_d && !op_i[0];
    assign div_zero_d   = (operand_b_i == '0);
    assign ovf_d        = div_signed_d && (operand_a_i == MIN_NEG) && (operand_b_i == '1);
    assign abs_a_d      = (div_signed_d && operand_a_i[XLEN-1]) ? -operand_a_i : operand_a_i;
    assign abs_b_d      = (div_signed_d && operand_b_i[XLEN-1]) ? -operand_b_i : operand_b_i;

    // Special-case result: op_i[1] selects remainder flavours.
    // Overflow gives quotient = a, remainder = 0; div-by-zero gives
    // quotient = all ones, remainder = a.
    assign spec_res_d = op_i[1] ? (div_zero_d ? operand_a_i : '0)
                                : (div_zero_d ? '1 : operand_a_i);

    // ------------------------------------------------------------------
    // Multiplier: operands sign/zero extended to 2*XLEN so a single
    // unsigned product gives the correct low 2*XLEN bits for all flavours.
    // ------------------------------------------------------------------
    logic              mul_a_sign;
    logic              mul_b_sign;
    logic [2*XLEN-1:0] mul_a_ext;
    logic [2*XLEN-1:0] mul_b_ext;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   mul_res;

    assign mul_a_sign = a_q[XLEN-1] && ((op_q == 2'd1) || (op_q == 2'd2));
    assign mul_b_sign = b_q[XLEN-1] && (op_q == 2'd1);
    assign mul_a_ext  = {{XLEN{mul_a_sign}}, a_q};
    assign mul_b_ext  = {{XLEN{mul_b_sign}}, b_q};
    assign mul_prod   = mul_a_ext * mul_b_ext;
    assign mul_res    = (op_q == 2'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    // ------------------------------------------------------------------
    // Restoring divider step: shift next dividend bit into the partial
    // remainder, subtract the divisor, keep the difference if non-negative.
    // ------------------------------------------------------------------
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_bit;
    logic [XLEN-1:0] rem_d;
    logic [XLEN-1:0] quo_d;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] div_res;

    assign div_shift = {rem_q, a_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_bit   = ~div_diff[XLEN];
    assign rem_d     = div_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    assign quo_d     = {a_q[XLEN-2:0], div_bit};

    assign quo_fix = neg_quo_q ? -a_q : a_q;
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;
    // With EARLY_OUT=0 the special cases still run the full iteration, and
    // the fix cycle substitutes the architecturally required value.
    assign div_res = special_q ? spec_res_q : (op_q[1] ? rem_fix : quo_fix);

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rem_q        <= '0;
            result_q     <= '0;
            spec_res_q   <= '0;
            last_wdata_q <= '0;
            rd_q         <= '0;
            last_waddr_q <= '0;
            we_q         <= 1'b0;
            special_q    <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
        end else if (kill_i) begin
            state_q <= S_IDLE;
        end else begin
            // Remember the delivered result so the outputs hold it afterwards.
            if (resp_valid_o) begin
                last_wdata_q <= result_q;
                last_waddr_q <= rd_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        op_q       <= op_i[1:0];
                        rd_q       <= rd_addr_i;
                        we_q       <= rd_we_i && (rd_addr_i != 5'd0);
                        special_q  <= is_div_d && (div_zero_d || ovf_d);
                        spec_res_q <= spec_res_d;
                        neg_quo_q  <= div_signed_d && (operand_a_i[XLEN-1] ^ operand_b_i[XLEN-1]);
                        neg_rem_q  <= div_signed_d && operand_a_i[XLEN-1];
                        rem_q      <= '0;
                        if (is_div_d) begin
                            a_q     <= abs_a_d;
                            b_q     <= abs_b_d;
                            cnt_q   <= CNT_W'(XLEN - 1);
                            state_q <= S_DIV;
                        end else begin
                            a_q     <= operand_a_i;
                            b_q     <= operand_b_i;
                            cnt_q   <= CNT_W'(MUL_STAGES - 1);
                            state_q <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q == '0) begin
                        result_q <= mul_res;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if ((EARLY_OUT != 0) && special_q) begin
                        result_q <= spec_res_q;
                        state_q  <= S_DONE;
                    end else begin
                        a_q   <= quo_d;
                        rem_q <= rem_d;
                        if (cnt_q == '0) begin
                            state_q <= S_FIX;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                S_FIX: begin
                    result_q <= div_res;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Flush suppresses the strobe even in the DONE cycle; response fields
    // show the previously delivered values whenever there is no strobe.
    assign resp_valid_o    = (state_q == S_DONE) && !kill_i;
    assign resp_rd_we_o    = resp_valid_o && we_q;
    assign resp_rd_waddr_o = resp_valid_o ? rd_q : last_waddr_q;
    assign resp_wdata_o    = resp_valid_o ? result_q : last_wdata_q;
    assign req_ready_o     = (state_q == S_IDLE) && !kill_i;
    assign busy_o          = (state_q != S_IDLE);
    assign stallreq_o      = (busy_o || req_valid_i) && !resp_valid_o && !kill_i;

endmodule

// File: tb/tb_ex_md_unit.sv
// ============================================================================
// tb_ex_md_unit
// ----------------------------------------------------------------------------
// Drives two copies of ex_md_unit in lockstep (EARLY_OUT=1 and EARLY_OUT=0)
// and compares results, latencies and handshake signals against a reference
// model built from plain SystemVerilog arithmetic.
// ============================================================================
module tb_ex_md_unit;

    localparam int XLEN  = 32;
    localparam int MULST = 2;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        reqValid = 1'b0;
    logic        kill     = 1'b0;
    logic        rdWe     = 1'b0;
    logic [2:0]  op       = 3'd0;
    logic [31:0] opA      = '0;
    logic [31:0] opB      = '0;
    logic [4:0]  rdAddr   = '0;

    logic [1:0]       reqReady;
    logic [1:0]       respValid;
    logic [1:0]       respRdWe;
    logic [1:0]       busy;
    logic [1:0]       stallReq;
    logic [1:0][4:0]  respWaddr;
    logic [1:0][31:0] respWdata;

    int checks = 0;
    int errors = 0;

    ex_md_unit #(.XLEN(XLEN), .MUL_STAGES(MULST), .EARLY_OUT(1)) dutEo (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(reqValid), .req_ready_o(reqReady[0]),
        .op_i(op), .operand_a_i(opA), .operand_b_i(opB),
        .rd_addr_i(rdAddr), .rd_we_i(rdWe), .kill_i(kill),
        .resp_valid_o(respValid[0]), .resp_rd_we_o(respRdWe[0]),
        .resp_rd_waddr_o(respWaddr[0]), .resp_wdata_o(respWdata[0]),
        .busy_o(busy[0]), .stallreq_o(stallReq[0])
    );

    ex_md_unit #(.XLEN(XLEN), .MUL_STAGES(MULST), .EARLY_OUT(0)) dutNo (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(reqValid), .req_ready_o(reqReady[1]),
        .op_i(op), .operand_a_i(opA), .operand_b_i(opB),
        .rd_addr_i(rdAddr), .rd_we_i(rdWe), .kill_i(kill),
        .resp_valid_o(respValid[1]), .resp_rd_we_o(respRdWe[1]),
        .resp_rd_waddr_o(respWaddr[1]), .resp_wdata_o(respWdata[1]),
        .busy_o(busy[1]), .stallreq_o(stallReq[1])
    );

    // Reference result from the RV32M definitions.
    function automatic logic [31:0] refResult(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        logic        ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = (a == MIN_NEG) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[31:0]; end
            3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[63:32]; end
            3'd2: begin sp = longint'($signed(a)) * longint'({32'd0, b}); return sp[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return sa / sb;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return sa % sb;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Cycles from the accept edge until the result strobe.
    function automatic int refLatency(input logic [2:0] o, input logic [31:0] a,
                                      input logic [31:0] b, input bit earlyOut);
        if (o < 3'd4) return MULST;
        if (earlyOut && ((b == 0) || ((o == 3'd4 || o == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF)))
            return 1;
        return XLEN + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation to both units and check its response and the
    // held outputs in the cycle that follows.
    task automatic applyStimulus(input string tag, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd, input logic we);
        logic [31:0] expData;
        int          lat    [2];
        logic [31:0] gotData[2];
        logic        gotWe  [2];
        logic [4:0]  gotAddr[2];
        expData = refResult(o, a, b);
        checkOutput($sformatf("%s/ready", tag), 64'(reqReady), 64'(2'b11));
        reqValid = 1'b1;
        op = o; opA = a; opB = b; rdAddr = rd; rdWe = we;
        sync();
        reqValid = 1'b0;
        #1;
        checkOutput($sformatf("%s/stall0", tag), 64'(stallReq), 64'(2'b11));
        lat[0] = -1;
        lat[1] = -1;
        for (int cyc = 0; cyc < 60 && (lat[0] < 0 || lat[1] < 0); cyc++) begin
            for (int d = 0; d < 2; d++) begin
                if (lat[d] < 0 && respValid[d]) begin
                    lat[d]     = cyc;
                    gotData[d] = respWdata[d];
                    gotWe[d]   = respRdWe[d];
                    gotAddr[d] = respWaddr[d];
                end
            end
            if (lat[0] < 0 || lat[1] < 0) sync();
        end
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s/d%0d/latency", tag, d), 64'(lat[d]),
                        64'(refLatency(o, a, b, d == 0)));
            checkOutput($sformatf("%s/d%0d/data", tag, d), 64'(gotData[d]), 64'(expData));
            checkOutput($sformatf("%s/d%0d/rdwe", tag, d), 64'(gotWe[d]), 64'(we && rd != 0));
            checkOutput($sformatf("%s/d%0d/waddr", tag, d), 64'(gotAddr[d]), 64'(rd));
        end
        sync();
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("%s/d%0d/holdData", tag, d), 64'(respWdata[d]), 64'(expData));
            checkOutput($sformatf("%s/d%0d/holdWe", tag, d), 64'(respRdWe[d]), 64'(0));
        end
    endtask

    initial begin
        int          quiet;
        logic [31:0] prevData;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        // Reset state
        #1 rst = 1'b1;
        #1;
        checkOutput("reset/ready", 64'(reqReady), 64'(2'b11));
        checkOutput("reset/valid", 64'(respValid), 64'(0));
        checkOutput("reset/wdata", 64'(respWdata), 64'(0));
        checkOutput("reset/waddr", 64'(respWaddr), 64'(0));
        checkOutput("reset/rdwe", 64'(respRdWe), 64'(0));
        checkOutput("reset/busy", 64'(busy), 64'(0));
        checkOutput("reset/stall", 64'(stallReq), 64'(0));
        sync();
        sync();
        #2 rst = 1'b0;
        sync();

        // Multiplies
        applyStimulus("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
        applyStimulus("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1);
        applyStimulus("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd7, 1'b1);
        applyStimulus("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b1);

        // Divides and remainders
        applyStimulus("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1);
        applyStimulus("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1);
        applyStimulus("divu", 3'd5, 32'd100, 32'd7, 5'd11, 1'b1);
        applyStimulus("remu", 3'd7, 32'd100, 32'd7, 5'd12, 1'b1);

        // Early-out cases
        applyStimulus("divu0", 3'd5, 32'd5, 32'd0, 5'd13, 1'b1);
        applyStimulus("rem0", 3'd6, 32'd5, 32'd0, 5'd14, 1'b1);
        applyStimulus("divOvf", 3'd4, MIN_NEG, 32'hFFFF_FFFF, 5'd15, 1'b1);
        applyStimulus("remOvf", 3'd6, MIN_NEG, 32'hFFFF_FFFF, 5'd16, 1'b1);
        applyStimulus("divNeg0", 3'd4, 32'hFFFF_FFF0, 32'd0, 5'd17, 1'b1);

        // Destination x0 and disabled write enable
        applyStimulus("rdZero", 3'd0, 32'd3, 32'd4, 5'd0, 1'b1);
        applyStimulus("weOff", 3'd5, 32'd81, 32'd9, 5'd3, 1'b0);

        // Flush in the middle of a divide
        reqValid = 1'b1; op = 3'd4; opA = 32'd1000; opB = 32'd3; rdAddr = 5'd4; rdWe = 1'b1;
        sync();
        reqValid = 1'b0;
        repeat (10) sync();
        kill = 1'b1;
        #1;
        checkOutput("kill/ready", 64'(reqReady), 64'(0));
        checkOutput("kill/valid", 64'(respValid), 64'(0));
        checkOutput("kill/stall", 64'(stallReq), 64'(0));
        sync();
        kill = 1'b0;
        #1;
        checkOutput("kill/readyAfter", 64'(reqReady), 64'(2'b11));
        checkOutput("kill/busyAfter", 64'(busy), 64'(0));
        quiet = 0;
        for (int i = 0; i < 40; i++) begin
            if (respValid != 2'b00) quiet++;
            sync();
        end
        checkOutput("kill/noStrobe", 64'(quiet), 64'(0));

        // Request presented together with a flush is ignored
        kill = 1'b1; reqValid = 1'b1; op = 3'd0; opA = 32'd2; opB = 32'd2;
        sync();
        kill = 1'b0; reqValid = 1'b0;
        #1;
        checkOutput("killReq/busy", 64'(busy), 64'(0));
        applyStimulus("mulAfterKill", 3'd0, 32'd11, 32'd13, 5'd20, 1'b1);
        prevData = 32'd143;

        // Flush in the DONE cycle suppresses the strobe
        reqValid = 1'b1; op = 3'd0; opA = 32'd5; opB = 32'd6; rdAddr = 5'd21; rdWe = 1'b1;
        sync();
        reqValid = 1'b0;
        sync();
        sync();
        checkOutput("killDone/validBefore", 64'(respValid), 64'(2'b11));
        kill = 1'b1;
        #1;
        checkOutput("killDone/valid", 64'(respValid), 64'(0));
        checkOutput("killDone/rdwe", 64'(respRdWe), 64'(0));
        checkOutput("killDone/heldData", 64'(respWdata[0]), 64'(prevData));
        sync();
        kill = 1'b0;
        #1;
        checkOutput("killDone/busy", 64'(busy), 64'(0));
        checkOutput("killDone/validAfter", 64'(respValid), 64'(0));
        checkOutput("killDone/heldAfter", 64'(respWdata[1]), 64'(prevData));

        // Asynchronous reset in the middle of a divide
        reqValid = 1'b1; op = 3'd5; opA = 32'd1000; opB = 32'd7; rdAddr = 5'd22; rdWe = 1'b1;
        sync();
        reqValid = 1'b0;
        repeat (5) sync();
        #2 rst = 1'b1;
        #1;
        checkOutput("rstMid/valid", 64'(respValid), 64'(0));
        checkOutput("rstMid/wdata", 64'(respWdata), 64'(0));
        checkOutput("rstMid/waddr", 64'(respWaddr), 64'(0));
        checkOutput("rstMid/busy", 64'(busy), 64'(0));
        checkOutput("rstMid/ready", 64'(reqReady), 64'(2'b11));
        sync();
        #2 rst = 1'b0;
        sync();
        applyStimulus("divuAfterRst", 3'd5, 32'd9, 32'd3, 5'd23, 1'b1);

        // Randomised operations
        for (int i = 0; i < 40; i++) begin
            ro  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = MIN_NEG; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            else if (sel == 3) ra = 32'($urandom_range(0, 255));
            applyStimulus($sformatf("rand%0d", i), ro, ra, rb,
                          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
